// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: keypad pins plus the decoded key-event outputs.
// master is the scanner side; slave is the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       KeyValid;
  logic [3:0] KeyCode;
  logic       Digit;
  logic       Add;
  logic       Sub;
  logic       Mult;
  logic       Div;
  logic       Start;
  logic       ClrKey;

  modport master (
    input  rows,
    output cols, KeyValid, KeyCode, Digit, Add, Sub, Mult, Div, Start, ClrKey
  );

  modport slave (
    output rows,
    input  cols, KeyValid, KeyCode, Digit, Add, Sub, Mult, Div, Start, ClrKey
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchroniser, press/release debounce and
// one-cycle decoded key events.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 20000
) (
  input logic              Clock,
  input logic              Clear_n,
  keypad_scanner_if.master kp
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned DbW    = $clog2(DEBOUNCE + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE);

  typedef enum logic [1:0] {StScan, StPressDb, StHold, StRelDb} state_e;

  state_e            state_q;
  logic [3:0]        rows_m_q, rows_s_q;
  logic [3:0]        pattern_q;
  logic [1:0]        row_q;
  logic [1:0]        col_q;
  logic [3:0]        cols_q;
  logic [DwellW-1:0] dwell_q;
  logic [DbW-1:0]    db_q;
  logic              key_valid_q;
  logic [3:0]        code_q;
  // {Digit, Add, Sub, Mult, Div, Start, ClrKey}
  logic [6:0]        class_q;

  logic       one_low;
  logic [1:0] row_idx;
  logic [3:0] key_code;
  logic [6:0] key_class;

  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (rows_s_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    key_code = 4'h0;
    case ({row_q, col_q})
      4'd0:  key_code = 4'h1;
      4'd1:  key_code = 4'h2;
      4'd2:  key_code = 4'h3;
      4'd3:  key_code = 4'hA;
      4'd4:  key_code = 4'h4;
      4'd5:  key_code = 4'h5;
      4'd6:  key_code = 4'h6;
      4'd7:  key_code = 4'hB;
      4'd8:  key_code = 4'h7;
      4'd9:  key_code = 4'h8;
      4'd10: key_code = 4'h9;
      4'd11: key_code = 4'hC;
      4'd12: key_code = 4'hE;
      4'd13: key_code = 4'h0;
      4'd14: key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  end

  always_comb begin
    key_class = 7'b0000000;
    if (key_code <= 4'h9) begin
      key_class = 7'b1000000;
    end else begin
      case (key_code)
        4'hA:    key_class = 7'b0100000;
        4'hB:    key_class = 7'b0010000;
        4'hC:    key_class = 7'b0001000;
        4'hD:    key_class = 7'b0000100;
        4'hF:    key_class = 7'b0000010;
        default: key_class = 7'b0000001;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q     <= StScan;
      rows_m_q    <= 4'hF;
      rows_s_q    <= 4'hF;
      pattern_q   <= 4'hF;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      cols_q      <= 4'b1110;
      dwell_q     <= '0;
      db_q        <= '0;
      key_valid_q <= 1'b0;
      code_q      <= 4'h0;
      class_q     <= 7'b0000000;
    end else begin
      rows_m_q    <= kp.rows;
      rows_s_q    <= rows_m_q;
      key_valid_q <= 1'b0;
      class_q     <= 7'b0000000;
      unique case (state_q)
        StScan: begin
          if (dwell_q != DwellLast) begin
            dwell_q <= dwell_q + DwellW'(1);
          end else begin
            dwell_q <= '0;
            if (one_low) begin
              row_q     <= row_idx;
              pattern_q <= rows_s_q;
              db_q      <= DbW'(1);
              state_q   <= StPressDb;
            end else begin
              col_q  <= col_q + 2'd1;
              cols_q <= {cols_q[2:0], cols_q[3]};
            end
          end
        end
        StPressDb: begin
          if (rows_s_q != pattern_q) begin
            // Any bounce abandons the press; scanning resumes on the next column.
            state_q <= StScan;
            db_q    <= '0;
            col_q   <= col_q + 2'd1;
            cols_q  <= {cols_q[2:0], cols_q[3]};
          end else if (db_q == DbLast) begin
            state_q     <= StHold;
            db_q        <= '0;
            key_valid_q <= 1'b1;
            class_q     <= key_class;
            code_q      <= key_code;
          end else begin
            db_q <= db_q + DbW'(1);
          end
        end
        StHold: begin
          if (rows_s_q == 4'hF) begin
            state_q <= StRelDb;
            db_q    <= DbW'(1);
          end
        end
        StRelDb: begin
          if (rows_s_q != 4'hF) begin
            state_q <= StHold;
            db_q    <= '0;
          end else if (db_q == DbLast) begin
            state_q <= StScan;
            db_q    <= '0;
            col_q   <= col_q + 2'd1;
            cols_q  <= {cols_q[2:0], cols_q[3]};
          end else begin
            db_q <= db_q + DbW'(1);
          end
        end
      endcase
    end
  end

  assign kp.cols     = cols_q;
  assign kp.KeyValid = key_valid_q;
  assign kp.KeyCode  = code_q;
  assign kp.Digit    = class_q[6];
  assign kp.Add      = class_q[5];
  assign kp.Sub      = class_q[4];
  assign kp.Mult     = class_q[3];
  assign kp.Div      = class_q[2];
  assign kp.Start    = class_q[1];
  assign kp.ClrKey   = class_q[0];

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, procedural reference scanner and
// directed plus randomized key sequences.
module tb_keypad_scanner;
  localparam int unsigned SD = 4;
  localparam int unsigned DB = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys  = '0;  // pressed keys, index row*4+col
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;

  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .Clock  (clk),
    .Clear_n(rst_n),
    .kp     (kp)
  );

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    logic [3:0] r_v;
    r_v = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && kp.cols[c] == 1'b0) r_v[r] = 1'b0;
      end
    end
    kp.rows = r_v;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [3:0] code_of(int k);
    case (k)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
      8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
      12: return 4'hE; 13: return 4'h0; 14: return 4'hF; default: return 4'hD;
    endcase
  endfunction

  // {Digit, Add, Sub, Mult, Div, Start, ClrKey}
  function automatic logic [6:0] class_of(logic [3:0] code);
    if (code <= 4'h9) return 7'b1000000;
    case (code)
      4'hA: return 7'b0100000;
      4'hB: return 7'b0010000;
      4'hC: return 7'b0001000;
      4'hD: return 7'b0000100;
      4'hF: return 7'b0000010;
      default: return 7'b0000001;
    endcase
  endfunction

  // ---------------- reference model ----------------
  int         m_col;
  logic [3:0] m_code;
  logic       m_kv;
  logic [6:0] m_cls;
  logic [3:0] rows_n = 4'hF;
  logic [3:0] rs1, rs2, rs;
  bit         m_abort;

  always @(negedge clk) rows_n = kp.rows;

  task automatic tick();
    @(posedge clk);
    rs  = rs2;
    rs2 = rs1;
    rs1 = rows_n;
    m_kv  = 1'b0;
    m_cls = 7'b0;
    if (!rst_n) m_abort = 1'b1;
  endtask

  task automatic run_model();
    logic [3:0] pat;
    int         row;
    bit         ok, released;
    forever begin
      repeat (SD) begin
        tick();
        if (m_abort) return;
      end
      if ($countones(~rs) == 1) begin
        pat = rs;
        row = 0;
        for (int r = 0; r < 4; r++) if (!pat[r]) row = r;
        ok = 1'b1;
        for (int i = 0; i < int'(DB); i++) begin
          tick();
          if (m_abort) return;
          if (rs != pat) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          m_code = code_of(row * 4 + m_col);
          m_kv   = 1'b1;
          m_cls  = class_of(m_code);
          released = 1'b0;
          while (!released) begin
            do begin
              tick();
              if (m_abort) return;
            end while (rs != 4'hF);
            released = 1'b1;
            for (int i = 0; i < int'(DB); i++) begin
              tick();
              if (m_abort) return;
              if (rs != 4'hF) begin
                released = 1'b0;
                break;
              end
            end
          end
        end
      end
      m_col = (m_col + 1) % 4;
    end
  endtask

  initial begin
    forever begin
      m_abort = 1'b0;
      m_col   = 0;
      m_code  = 4'h0;
      m_kv    = 1'b0;
      m_cls   = 7'b0;
      rs1 = 4'hF;
      rs2 = 4'hF;
      rs  = 4'hF;
      wait (rst_n === 1'b1);
      run_model();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [15:0] got, expv;
    logic [3:0]  one, exp_cols;
    if (rst_n) begin
      one      = 4'b0001;
      exp_cols = ~(one << m_col);
      got  = {kp.cols, kp.KeyValid, kp.KeyCode, kp.Digit, kp.Add, kp.Sub, kp.Mult,
              kp.Div, kp.Start, kp.ClrKey};
      expv = {exp_cols, m_kv, m_code, m_cls};
      n_checks++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL cycle_compare t=%0t got cols/kv/code/cls=%h required=%h", $time, got,
                 expv);
      end
    end
  end

  // ---------------- event monitor ----------------
  logic [3:0] ev_q[$];
  logic [6:0] ev_cls_q[$];
  int         ev_cyc_q[$];
  int         kv_double = 0;
  logic       kv_prev   = 1'b0;

  always @(negedge clk) begin
    if (rst_n && kp.KeyValid) begin
      ev_q.push_back(kp.KeyCode);
      ev_cls_q.push_back({kp.Digit, kp.Add, kp.Sub, kp.Mult, kp.Div, kp.Start, kp.ClrKey});
      ev_cyc_q.push_back(cyc);
      if (kv_prev) kv_double <= kv_double + 1;
    end
    kv_prev <= rst_n && kp.KeyValid;
  end

  // ---------------- helpers ----------------
  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_event(int base, int limit, string name);
    int n;
    n = 0;
    while (ev_q.size() <= base && n < limit) begin
      step(1);
      n++;
    end
    check({name, " event seen"}, int'(ev_q.size() > base), 1);
  endtask

  task automatic check_ev(int idx, logic [3:0] code, logic [6:0] cls, string name);
    check({name, " code"}, int'(ev_q[idx]), int'(code));
    check({name, " class"}, int'(ev_cls_q[idx]), int'(cls));
  endtask

  // Press, hold, release one key and wait for scanning to settle.
  task automatic tap(int k, string name);
    int base;
    base = ev_q.size();
    keys[k] = 1'b1;
    wait_event(base, 200, name);
    step(20);
    keys[k] = 1'b0;
    step(30);
    check({name, " single event"}, ev_q.size(), base + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, p, found;

    // Key "5" held from before its column is first driven.
    keys[5] = 1'b1;
    step(3);
    rst_n = 1'b1;
    wait_event(0, 100, "press5");
    check("press5 latency", ev_cyc_q[0], 16);
    check_ev(0, 4'h5, 7'b1000000, "press5");
    step(200);
    check("press5 no repeat", ev_q.size(), 1);
    check("press5 cols held", int'(kp.cols), 4'b1101);
    keys[5] = 1'b0;
    step(5);
    check("release5 cols e5", int'(kp.cols), 4'b1101);
    step(5);
    check("release5 cols e10", int'(kp.cols), 4'b1101);
    step(2);
    check("release5 cols e12", int'(kp.cols), 4'b1011);

    // Asynchronous reset mid-scan.
    step(3);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset cols", int'(kp.cols), 4'b1110);
    check("reset KeyCode", int'(kp.KeyCode), 0);
    check("reset pulses", int'({kp.KeyValid, kp.Digit, kp.Add, kp.Sub, kp.Mult, kp.Div,
                                kp.Start, kp.ClrKey}), 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("scan c0", int'(kp.cols), 4'b1110);
    step(1);
    check("scan c1", int'(kp.cols), 4'b1101);
    step(4);
    check("scan c2", int'(kp.cols), 4'b1011);
    step(4);
    check("scan c3", int'(kp.cols), 4'b0111);
    step(4);
    check("scan wrap", int'(kp.cols), 4'b1110);

    // Operator keys.
    base = ev_q.size();
    tap(11, "keyC");
    tap(14, "keyHash");
    tap(12, "keyStar");
    check_ev(base, 4'hC, 7'b0001000, "keyC");
    check_ev(base + 1, 4'hF, 7'b0000010, "keyHash");
    check_ev(base + 2, 4'hE, 7'b0000001, "keyStar");

    // Bounce on "A": low 3, high 1, then held.
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (kp.cols == 4'b0111) found = 1;
      else step(1);
    end
    check("bounce c3 reached", found, 1);
    base = ev_q.size();
    p = cyc;
    keys[3] = 1'b1;
    step(3);
    keys[3] = 1'b0;
    step(1);
    keys[3] = 1'b1;
    wait_event(base, 200, "bounceA");
    check("bounceA first attempt aborted", int'(ev_cyc_q[base] - p > 20), 1);
    check_ev(base, 4'hA, 7'b0100000, "bounceA");
    step(20);
    keys[3] = 1'b0;
    step(30);
    check("bounceA single event", ev_q.size(), base + 1);

    // Two keys in column 0.
    base = ev_q.size();
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    step(60);
    check("two keys no event", ev_q.size(), base);
    keys[4] = 1'b0;
    wait_event(base, 200, "key1");
    check_ev(base, 4'h1, 7'b1000000, "key1");
    step(10);
    keys[0] = 1'b0;
    step(30);

    // Release glitch on "0".
    base = ev_q.size();
    keys[13] = 1'b1;
    wait_event(base, 200, "key0");
    step(10);
    keys[13] = 1'b0;
    step(4);
    keys[13] = 1'b1;
    step(2);
    keys[13] = 1'b0;
    step(40);
    check("key0 glitch single event", ev_q.size(), base + 1);
    check_ev(base, 4'h0, 7'b1000000, "key0");

    // Reset during hold of "9".
    base = ev_q.size();
    keys[10] = 1'b1;
    wait_event(base, 200, "key9");
    step(5);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    wait_event(base + 1, 200, "key9 after reset");
    step(30);
    check("key9 one new event", ev_q.size(), base + 2);
    check_ev(base + 1, 4'h9, 7'b1000000, "key9 redetect");
    keys[10] = 1'b0;
    step(40);
    check("key9 no extra", ev_q.size(), base + 2);

    // Randomized presses, bounces, rollovers and resets against the model.
    for (int it = 0; it < 25; it++) begin
      int k, hold, k2;
      k = $urandom_range(15);
      keys[k] = 1'b1;
      hold = $urandom_range(80, 10);
      for (int t = 0; t < hold; t++) begin
        step(1);
        if ($urandom_range(15) == 0) keys[k] = ~keys[k];
      end
      if ($urandom_range(3) == 0) begin
        k2 = $urandom_range(15);
        keys[k2] = 1'b1;
        step($urandom_range(30, 5));
      end
      if ($urandom_range(11) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      keys = '0;
      step($urandom_range(60, 25));
    end

    check("KeyValid never back-to-back", kv_double, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives the 4x4 calculator keypad columns, synchronises and debounces the row returns, and turns each clean key press into a single-cycle, decoded key event. It sits directly upstream of the input unit. Its `cols` output goes to the keypad pins, and its strobes and key code replace raw row/column handling in the input path. One event is produced per physical press; auto-repeat is not supported.

## Interface
- `SCAN_DIV`, default 1000: cycles each column is driven before rows are sampled; minimum 3.
- `DEBOUNCE`, default 20000: consecutive identical cycles required to accept a press or a release; minimum 2.
- `Clock`  in  1  system clock.
- `Clear_n`  in  1  asynchronous, active-low reset; one clock domain only.
- `rows`  in  4  keypad rows, active-low with pull-ups; asynchronous to `Clock`.
- `cols`  out  4  column drive, active-low; exactly one bit is low at all times.
- `KeyValid`  out  1  one-cycle pulse for an accepted press.
- `KeyCode`  out  4  code of the last accepted key; held until the next press.
- `Digit`  out  1  pulse: the key is 0-9 (value on `KeyCode`).
- `Add`, `Sub`, `Mult`, `Div`  out  1 each  pulse: the key is A, B, C or D respectively.
- `Start`  out  1  pulse: the key is `#` (equals).
- `ClrKey`  out  1  pulse: the key is `*` (clear entry).

## Operation
- **Key map (row r, col c; row0 top, col0 left):**
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: `*`, 0, `#`, D
- **KeyCode values:** digits 0x0-0x9; A=0xA, B=0xB, C=0xC, D=0xD, `*`=0xE, `#`=0xF.
- **Row synchroniser:** `rows` passes through two flops, giving `rows_s`. All decisions use `rows_s`.
- **FSM states:** SCAN, PRESS_DB, HOLD, REL_DB.
- **SCAN:**
  - The dwell counter runs from 0 to SCAN_DIV-1 with the current column driven.
  - At count SCAN_DIV-1, if exactly one bit of `rows_s` is low: latch row and column, set the debounce counter to 1, and go to PRESS_DB.
  - Otherwise (no row low, or two or more rows low): advance the column (0,1,2,3, wrap to 0), clear the dwell counter, and stay in SCAN.
- **PRESS_DB:**
  - The column stays frozen.
  - Each cycle, `rows_s` equal to the latched pattern increments the counter.
  - Any mismatch returns to SCAN, advances the column and clears the counters; no event is produced.
  - When the counter reaches DEBOUNCE, go to HOLD.
- **HOLD entry:**
  - `KeyValid` and exactly one class strobe are asserted for the first HOLD cycle only.
  - `KeyCode` updates on that same cycle.
- **HOLD:**
  - The column stays frozen.
  - When `rows_s` is all ones, go to REL_DB with the counter at 1.
  - Other keys pressed meanwhile are ignored. There is no rollover.
- **REL_DB:**
  - All-ones `rows_s` increments the counter; any low bit returns to HOLD.
  - No new event is produced on that return.
  - When the counter reaches DEBOUNCE, go to SCAN on the next column with the dwell counter cleared.
- **Reset:** `Clear_n` low asynchronously forces:
  - state SCAN, column 0, `cols`=4'b1110;
  - all counters to 0;
  - `KeyCode`=0;
  - all pulses to 0.
- **Reset mid-press:** an event in progress is discarded. After release of reset, a still-held key is re-detected normally and yields one event.

## Timing
- All outputs are registered.
- `cols` changes only on the cycle after a column advance. A column is therefore driven for SCAN_DIV cycles per visit, or longer while a press is being processed.
- **Press latency:** a key held stable from before its column is driven gives `KeyValid` exactly DEBOUNCE cycles after the SCAN sampling edge.
- **Bounce:** a bounce of even one cycle inside PRESS_DB aborts the event. The earliest possible retry is 4 columns later.
- **Event spacing:** back-to-back presses give events at least 2·DEBOUNCE cycles apart.
- **Pulse exclusivity:** `KeyValid` is never high on two consecutive cycles. Exactly one of `Digit`/`Add`/`Sub`/`Mult`/`Div`/`Start`/`ClrKey` is high when `KeyValid` is high, and none otherwise.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE=8, with a bench keypad model that ties the rows to the driven column.
- **Reset:** drive `Clear_n`=0 mid-scan → `cols`=1110, `KeyCode`=0 and all pulses 0 immediately. After release, `cols` steps 1110→1101→1011→0111→1110 every 4 cycles.
- **Clean press:** hold key "5" (r1,c1) clean → one `KeyValid` with `Digit`=1 and `KeyCode`=0x5, 8 cycles after the c1 sample. Holding for 200 cycles produces no further pulse; `cols` stays 1101 until 8 cycles after release.
- **Operator keys:** press "C", then "#", then "*" with releases between → pulses `Mult`/0xC, then `Start`/0xF, then `ClrKey`/0xE; each event is one cycle wide.
- **Bounce:** toggle "A" (r0,c3) low for 3 cycles, high for 1, low for 20 → the first attempt aborts and scanning resumes. A single event `Add`/0xA follows on a later c3 visit.
- **Two keys in one column:** hold "1" and "4" (c0, rows 0 and 1) → no event and scanning continues. Releasing "4" → one event, 0x1.
- **Release bounce and reset during hold:**
  - Release "0" with a 2-cycle low glitch inside REL_DB → no second event.
  - Assert `Clear_n` during HOLD of "9" while the key stays held → after reset, exactly one new 0x9 event.
